risc_fetch_unit: RTL and testbench

- Parametrised instruction fetch and prefetch stage for the risc8-family cores.
- Issues in-order requests to instruction memory and buffers the returned words in a FIFO.
- Presents one complete variable-length bundle per handshake to the controller/datapath: an opcode plus 0..MAX_IMM immediates.
- Supports branch redirect with flush and discard of in-flight responses.

---
 rtl/risc_fetch_unit.sv | 133 +++++++++++++
 tb/tb_risc_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_fetch_unit.sv
`default_nettype none
// ============================================================================
// risc_fetch_unit : in-order instruction prefetch FIFO presenting one
//                   opcode+immediates bundle per handshake, with redirect flush.
// Revision 1.0
// ============================================================================
module risc_fetch_unit #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 16,
    parameter int                FIFO_DEPTH = 8,
    parameter int                MAX_IMM    = 3,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           imem_req,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic                           imem_gnt,
    input  logic                           imem_rvalid,
    input  logic [DATA_W-1:0]              imem_rdata,
    output logic [DATA_W-1:0]              peek_op,
    input  logic [$clog2(MAX_IMM+1)-1:0]   peek_len,
    output logic [DATA_W-1:0]              instr,
    output logic [MAX_IMM*DATA_W-1:0]      imm,
    output logic [ADDR_W-1:0]              pc,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    input  logic                           redirect,
    input  logic [ADDR_W-1:0]              redirect_addr
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int               LEN_W    = $clog2(MAX_IMM + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W+1)'(MAX_IMM);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pc_q;

    logic [LEN_W:0]    len;
    logic [CNT_W-1:0]  need;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  resp_dec;
    logic [DATA_W-1:0] entry [MAX_IMM+1];
    logic              fire_req;
    logic              push;
    logic              pop;

    // Entries beyond the current occupancy read as zero so stale storage never leaks out.
    always_comb begin
        len  = ({1'b0, peek_len} > LEN_MAX) ? LEN_MAX : {1'b0, peek_len};
        need = CNT_W'(len) + CNT_ONE;
        for (int k = 0; k <= MAX_IMM; k++) begin
            entry[k] = (CNT_W'(k) < count) ? fifo_mem[rd_ptr + PTR_W'(k)] : '0;
        end
    end

    // Credit covers both buffered words and words still in flight, so a push always has room.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = !rst && !redirect && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr   = fetch_addr;
    assign peek_op     = entry[0];
    assign instr       = entry[0];
    assign pc          = pc_q;
    assign instr_valid = !rst && !redirect && (count >= need);

    generate
        for (genvar k = 0; k < MAX_IMM; k++) begin : g_imm
            assign imm[k*DATA_W +: DATA_W] = ((LEN_W+1)'(k) < len) ? entry[k+1] : '0;
        end
    endgenerate

    assign fire_req = imem_req && imem_gnt;
    assign push     = imem_rvalid && !redirect && (discard == '0);
    assign pop      = instr_valid && instr_ready;
    assign resp_dec = imem_rvalid ? CNT_ONE : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_addr  <= RESET_PC;
            pc_q        <= RESET_PC;
        end else if (redirect) begin
            // Every word still in flight belongs to the abandoned path.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - resp_dec;
            discard     <= outstanding - resp_dec;
            fetch_addr  <= redirect_addr;
            pc_q        <= redirect_addr;
        end else begin
            if (fire_req) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end
            outstanding <= outstanding + (fire_req ? CNT_ONE : '0) - resp_dec;
            if (imem_rvalid && (discard != '0)) begin
                discard <= discard - CNT_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(need);
                pc_q   <= pc_q + ADDR_W'(need);
            end
            count <= count + (push ? CNT_ONE : '0) - (pop ? need : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= imem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_risc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_risc_fetch_unit : scoreboard bench for risc_fetch_unit with a
//                      variable-latency in-order memory model.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_risc_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [7:0]  imem_rdata = 8'h00;
    logic [7:0]  peek_op;
    logic [1:0]  peek_len;
    logic [7:0]  instr;
    logic [23:0] imm;
    logic [15:0] pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;

    always #5 clk = ~clk;

    risc_fetch_unit #(
        .DATA_W(8), .ADDR_W(16), .FIFO_DEPTH(8), .MAX_IMM(3), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .peek_op(peek_op), .peek_len(peek_len),
        .instr(instr), .imm(imm), .pc(pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_addr(redirect_addr)
    );

    // Controller length decode: 01xxxxxx -> 2 immediates, 11xxxxxx -> 3, else none.
    function automatic logic [1:0] decode(input logic [7:0] op);
        case (op[7:6])
            2'b01:   return 2'd2;
            2'b11:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction
    always_comb peek_len = decode(peek_op);

    // In-order memory: a grant at edge c returns its word in the cycle starting at edge c+lat-1.
    typedef struct { int due; logic [15:0] addr; } resp_t;
    logic [7:0]  mem [0:65535];
    resp_t       rq [$];
    int          lat = 1;
    int          cyc = 0;

    always @(posedge clk) begin
        resp_t r;
        if (rst) begin
            rq.delete();
            imem_rvalid <= 1'b0;
        end else begin
            if (imem_req && imem_gnt) begin
                r.due  = cyc + lat;
                r.addr = imem_addr;
                rq.push_back(r);
            end
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
                r = rq.pop_front();
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem[r.addr];
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    int          checks = 0;
    int          passes = 0;
    logic [47:0] exp_q [$];
    logic [47:0] got;
    logic [47:0] want;

    task automatic start_reset(input int latency);
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        lat = latency;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        exp_q.delete();
    endtask

    // Walks the memory image as the core would and queues {pc, opcode, immediates}.
    task automatic build_expected(input logic [15:0] start, input int n);
        logic [15:0] p;
        logic [7:0]  op;
        logic [1:0]  l;
        logic [23:0] im;
        p = start;
        for (int b = 0; b < n; b++) begin
            op = mem[p];
            l  = decode(op);
            im = '0;
            for (int k = 0; k < 3; k++) begin
                if (k < int'(l)) im[k*8 +: 8] = mem[p + 16'(k + 1)];
            end
            exp_q.push_back({p, op, im});
            p = p + 16'(l) + 16'd1;
        end
    endtask

    task automatic test_reset;
        start_reset(1);
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL reset imem_req: got %b want 0", imem_req); else passes++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL reset instr_valid: got %b want 0", instr_valid); else passes++;
        checks++; if (instr !== 8'h00) $display("FAIL reset instr: got %h want 00", instr); else passes++;
        checks++; if (imm !== 24'h0) $display("FAIL reset imm: got %h want 000000", imm); else passes++;
        checks++; if (peek_op !== 8'h00) $display("FAIL reset peek_op: got %h want 00", peek_op); else passes++;
        checks++; if (pc !== RESET_PC) $display("FAIL reset pc: got %h want %h", pc, RESET_PC); else passes++;
    endtask

    task automatic test_straight;
        int k;
        int budget;
        start_reset(1);
        for (int a = 0; a < 4; a++) mem[a] = 8'h10 + 8'(a);
        build_expected(16'h0000, 4);
        rst = 1'b0;
        k = 0;
        while (!instr_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++; if (k !== 2) $display("FAIL straight first_valid_latency: got %0d want 2", k); else passes++;
        @(negedge clk);
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL straight bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL straight timeout: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    task automatic test_multi_word;
        int budget;
        start_reset(1);
        mem[0] = 8'h40; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'h10;
        build_expected(16'h0000, 2);
        rst = 1'b0;
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL multi_word bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL multi_word timeout: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    task automatic test_backpressure;
        int grants;
        int budget;
        start_reset(1);
        for (int a = 0; a < 32; a++) mem[a] = 8'h20 + 8'(a);
        build_expected(16'h0000, 12);
        rst = 1'b0;
        grants = 0;
        repeat (20) begin
            #1;
            if (imem_req && imem_gnt) grants++;
            @(negedge clk);
        end
        #1;
        checks++; if (grants !== 8) $display("FAIL backpressure grants: got %0d want 8", grants); else passes++;
        checks++; if (imem_req !== 1'b0) $display("FAIL backpressure req_held: got %b want 0", imem_req); else passes++;
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL backpressure bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL backpressure timeout: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    task automatic test_redirect(input bit back_to_back);
        int budget;
        start_reset(4);
        for (int a = 0; a < 8; a++) mem[a] = 8'h11;
        for (int a = 0; a < 4; a++) mem[16'h0100 + 16'(a)] = 8'h30 + 8'(a);
        mem[16'h0200] = 8'h3F;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_addr = back_to_back ? 16'h0200 : 16'h0100;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL redirect req_in_R: got %b want 0", imem_req); else passes++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL redirect valid_in_R: got %b want 0", instr_valid); else passes++;
        if (back_to_back) begin
            @(negedge clk);
            redirect_addr = 16'h0100;
            #1;
            checks++; if (imem_req !== 1'b0) $display("FAIL back_to_back req_in_R1: got %b want 0", imem_req); else passes++;
        end
        @(negedge clk);
        redirect = 1'b0;
        build_expected(16'h0100, 3);
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL redirect bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL redirect timeout: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    task automatic test_wrap;
        int          budget;
        logic [15:0] addrs [$];
        logic [15:0] want_addr [3];
        want_addr[0] = 16'hFFFE; want_addr[1] = 16'hFFFF; want_addr[2] = 16'h0000;
        start_reset(1);
        mem[16'hFFFE] = 8'h21; mem[16'hFFFF] = 8'h22; mem[0] = 8'h23; mem[1] = 8'h24;
        rst = 1'b0;
        redirect = 1'b1;
        redirect_addr = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        build_expected(16'hFFFE, 3);
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (imem_req && imem_gnt && addrs.size() < 3) addrs.push_back(imem_addr);
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL wrap bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL wrap timeout: got %0d left want 0", exp_q.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= addrs.size()) $display("FAIL wrap imem_addr[%0d]: got none want %h", i, want_addr[i]);
            else if (addrs[i] !== want_addr[i]) $display("FAIL wrap imem_addr[%0d]: got %h want %h", i, addrs[i], want_addr[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int budget;
        start_reset(1);
        mem[0] = 8'h40; mem[1] = 8'hA1; mem[2] = 8'hA2;
        for (int a = 3; a < 16; a++) mem[a] = 8'h10 + 8'(a);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b1) $display("FAIL reset_mid valid_before: got %b want 1", instr_valid); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) $display("FAIL reset_mid instr_valid: got %b want 0", instr_valid); else passes++;
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_mid imem_req: got %b want 0", imem_req); else passes++;
        checks++; if (peek_op !== 8'h00) $display("FAIL reset_mid peek_op: got %h want 00", peek_op); else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) $display("FAIL reset_mid restart_req: got %b want 1", imem_req); else passes++;
        checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_mid restart_addr: got %h want %h", imem_addr, RESET_PC); else passes++;
        build_expected(RESET_PC, 2);
        instr_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            #1;
            if (instr_valid) begin
                got = {pc, instr, imm};
                want = exp_q.pop_front();
                checks++; if (got !== want) $display("FAIL reset_mid bundle: got %h want %h", got, want); else passes++;
            end
            budget++;
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL reset_mid timeout: got %0d left want 0", exp_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_multi_word();
        test_backpressure();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
